// File: rtl/rr_mux_arb.sv
// Round-robin arbiter for two valid/ready byte producers feeding a 2:1 mux select,
// with a small source-tagged output FIFO toward a valid/ready consumer.
module rr_mux_arb #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              sel_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_data_o,
    output logic              y_src_o,
    input  logic              y_ready_i
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // Producers hold valid/data until ready; ready may depend combinationally on valid.

    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              last_grant;   // 0 = A, 1 = B
    logic              can_push;
    logic              grant_a;
    logic              grant_b;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;

    // A pop in the same cycle does not free a slot: fullness uses registered count only.
    assign can_push = (count < CNT_W'(FIFO_DEPTH));

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && can_push) begin
            if (a_valid_i && b_valid_i) begin
                if (last_grant) grant_a = 1'b1;
                else            grant_b = 1'b1;
            end else if (a_valid_i) begin
                grant_a = 1'b1;
            end else if (b_valid_i) begin
                grant_b = 1'b1;
            end
        end
    end

    assign push      = grant_a | grant_b;
    assign pop       = (count != '0) && y_ready_i;
    assign push_data = grant_b ? b_data_i : a_data_i;

    assign a_ready_o = grant_a;
    assign b_ready_o = grant_b;
    assign sel_o     = grant_b;

    assign y_valid_o             = (count != '0);
    assign {y_src_o, y_data_o}   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {grant_b, push_data};
                wr_ptr      <= wr_ptr + PTR_W'(1);
                last_grant  <= grant_b;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed vector table plus hand sequences and a randomized scoreboard run for rr_mux_arb.
module tb_rr_mux_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid_i;
    logic [7:0] a_data_i;
    logic       a_ready_o;
    logic       b_valid_i;
    logic [7:0] b_data_i;
    logic       b_ready_o;
    logic       sel_o;
    logic       y_valid_o;
    logic [7:0] y_data_o;
    logic       y_src_o;
    logic       y_ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    rr_mux_arb #(.DATA_W(8), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid_i (a_valid_i),
        .a_data_i  (a_data_i),
        .a_ready_o (a_ready_o),
        .b_valid_i (b_valid_i),
        .b_data_i  (b_data_i),
        .b_ready_o (b_ready_o),
        .sel_o     (sel_o),
        .y_valid_o (y_valid_o),
        .y_data_o  (y_data_o),
        .y_src_o   (y_src_o),
        .y_ready_i (y_ready_i)
    );

    typedef struct {
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic       yr;
        logic       e_ar;
        logic       e_br;
        logic       e_sel;
        logic       e_yv;
        logic [7:0] e_yd;
        logic       e_ys;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic av, logic [7:0] ad, logic bv, logic [7:0] bd, logic yr,
                                logic e_ar, logic e_br, logic e_sel, logic e_yv,
                                logic [7:0] e_yd, logic e_ys);
        vec_t v;
        v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.yr = yr;
        v.e_ar = e_ar; v.e_br = e_br; v.e_sel = e_sel;
        v.e_yv = e_yv; v.e_yd = e_yd; v.e_ys = e_ys;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [7:0] ad, input logic bv,
                         input logic [7:0] bd, input logic yr);
        a_valid_i = av; a_data_i = ad;
        b_valid_i = bv; b_data_i = bd;
        y_ready_i = yr;
    endtask

    task automatic chk_out(input string tag, input logic ar, input logic br, input logic sel,
                           input logic yv, input logic [7:0] yd, input logic ys);
        chk({tag, " a_ready"}, a_ready_o, ar);
        chk({tag, " b_ready"}, b_ready_o, br);
        chk({tag, " sel"},     sel_o,     sel);
        chk({tag, " y_valid"}, y_valid_o, yv);
        if (yv) begin
            chk({tag, " y_data"}, y_data_o, yd);
            chk({tag, " y_src"},  y_src_o,  ys);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic m_lg;
        logic ga, gb, a_pend, b_pend, pop_now;

        // Test 1-4 vectors, applied back-to-back from reset
        vecs[0]  = mk(1, 8'h11, 0, 8'h00, 1,  1, 0, 0, 0, 8'h00, 0);
        vecs[1]  = mk(1, 8'h22, 0, 8'h00, 1,  1, 0, 0, 1, 8'h11, 0);
        vecs[2]  = mk(1, 8'h33, 0, 8'h00, 1,  1, 0, 0, 1, 8'h22, 0);
        vecs[3]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 1, 8'h33, 0);
        vecs[4]  = mk(0, 8'h00, 1, 8'h44, 1,  0, 1, 1, 0, 8'h00, 0);
        vecs[5]  = mk(1, 8'h55, 1, 8'h66, 1,  1, 0, 0, 1, 8'h44, 1);
        vecs[6]  = mk(1, 8'h57, 1, 8'h66, 1,  0, 1, 1, 1, 8'h55, 0);
        vecs[7]  = mk(1, 8'h57, 1, 8'h77, 1,  1, 0, 0, 1, 8'h66, 1);
        vecs[8]  = mk(1, 8'h58, 1, 8'h77, 1,  0, 1, 1, 1, 8'h57, 0);
        vecs[9]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 1, 8'h77, 1);
        vecs[10] = mk(1, 8'hA1, 1, 8'hB1, 0,  1, 0, 0, 0, 8'h00, 0);
        vecs[11] = mk(1, 8'hA2, 1, 8'hB1, 0,  0, 1, 1, 1, 8'hA1, 0);
        vecs[12] = mk(1, 8'hA2, 1, 8'hB2, 0,  0, 0, 0, 1, 8'hA1, 0);
        vecs[13] = mk(1, 8'hA2, 1, 8'hB2, 0,  0, 0, 0, 1, 8'hA1, 0);
        vecs[14] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 1, 8'hA1, 0);
        vecs[15] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 1, 8'hB1, 1);
        vecs[16] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 8'h00, 0);
        vecs[17] = mk(1, 8'hC1, 0, 8'h00, 0,  1, 0, 0, 0, 8'h00, 0);
        vecs[18] = mk(1, 8'hC2, 0, 8'h00, 0,  1, 0, 0, 1, 8'hC1, 0);
        vecs[19] = mk(1, 8'hC3, 0, 8'h00, 1,  0, 0, 0, 1, 8'hC1, 0);
        vecs[20] = mk(1, 8'hC3, 0, 8'h00, 1,  1, 0, 0, 1, 8'hC2, 0);
        vecs[21] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 1, 8'hC3, 0);
        vecs[22] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 8'h00, 0);

        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 8'h00, 0);
        chk("reset y_data", y_data_o, 8'h00);
        chk("reset y_src",  y_src_o,  1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].yr);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_ar, vecs[i].e_br, vecs[i].e_sel,
                    vecs[i].e_yv, vecs[i].e_yd, vecs[i].e_ys);
            @(negedge clk);
        end

        // Reset with one B entry buffered and B still valid
        drive(1'b0, 8'h00, 1'b1, 8'hD5, 1'b0);
        #1;
        chk_out("rst_seq push", 0, 1, 1, 0, 8'h00, 0);
        @(negedge clk);
        #1;
        chk("rst_seq pre y_valid", y_valid_o, 1'b1);
        chk("rst_seq pre y_data",  y_data_o,  8'hD5);
        reset = 1'b1;
        #1;
        chk_out("rst_seq during", 0, 0, 0, 0, 8'h00, 0);
        chk("rst_seq y_data cleared", y_data_o, 8'h00);
        chk("rst_seq y_src cleared",  y_src_o,  1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 8'hE1, 1'b1, 8'hD5, 1'b0);
        #1;
        chk_out("rst_seq tie", 1, 0, 0, 0, 8'h00, 0);
        @(negedge clk);
        drive(1'b1, 8'hE2, 1'b1, 8'hD5, 1'b1);
        #1;
        chk_out("rst_seq second", 0, 1, 1, 1, 8'hE1, 0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #1;
        chk_out("rst_seq drain", 0, 0, 0, 1, 8'hD5, 1);
        @(negedge clk);
        #1;
        chk_out("rst_seq empty", 0, 0, 0, 0, 8'h00, 0);

        // Randomized run against a behavioural model
        do_reset();
        m_lg   = 1'b1;
        a_pend = 1'b0;
        b_pend = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 1000; i++) begin
            if (!a_pend) begin
                a_valid_i = ($urandom_range(0, 99) < 60);
                a_data_i  = 8'($urandom_range(0, 255));
            end
            if (!b_pend) begin
                b_valid_i = ($urandom_range(0, 99) < 60);
                b_data_i  = 8'($urandom_range(0, 255));
            end
            y_ready_i = ($urandom_range(0, 99) < 50);
            #1;
            ga = 1'b0;
            gb = 1'b0;
            if (exp_q.size() < 2) begin
                if (a_valid_i && b_valid_i) begin
                    ga = m_lg;
                    gb = !m_lg;
                end else begin
                    ga = a_valid_i;
                    gb = b_valid_i;
                end
            end
            chk("rnd a_ready", a_ready_o, ga);
            chk("rnd b_ready", b_ready_o, gb);
            chk("rnd ready exclusive", a_ready_o & b_ready_o, 1'b0);
            chk("rnd sel", sel_o, gb);
            chk("rnd y_valid", y_valid_o, exp_q.size() != 0);
            if (y_valid_o && exp_q.size() != 0)
                chk("rnd y_head", {y_src_o, y_data_o}, exp_q[0]);
            pop_now = (exp_q.size() != 0) && y_ready_i;
            if (pop_now) void'(exp_q.pop_front());
            if (ga) begin
                exp_q.push_back({1'b0, a_data_i});
                m_lg = 1'b0;
            end
            if (gb) begin
                exp_q.push_back({1'b1, b_data_i});
                m_lg = 1'b1;
            end
            a_pend = a_valid_i && !ga;
            b_pend = b_valid_i && !gb;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
